// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : dbus_responder
// Description : Data-bus slave with a RAM region, a free-running COUNTER
//               register and a push-only output FIFO with STATUS/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int         c_IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int         c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] c_DEPTH = 4'(FIFO_DEPTH);

    logic [31:0]        r_ram [RAM_WORDS];
    logic [31:0]        r_fifo [FIFO_DEPTH];
    logic [31:0]        r_counter;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [3:0]         r_count;
    logic               r_ovf;

    logic [c_IDX_W-1:0] w_idx;
    logic               w_ram_sel;
    logic               w_cnt_sel;
    logic               w_fifo_sel;
    logic               w_stat_sel;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_pop;
    logic               w_push_ok;
    logic               w_ovf_set;
    logic               w_ovf_clr;
    logic [31:0]        w_status;
    logic               w_unused_abits;

    // Byte-lane bits and (for small RAMs) aliased index bits carry no meaning
    assign w_unused_abits = &{1'b0, a[7:0]};

    // Address decode; the low two address bits are ignored everywhere
    assign w_idx      = a[2 +: c_IDX_W];
    assign w_ram_sel  = (a[31:8] == 24'd0);
    assign w_cnt_sel  = (a[31:2] == 30'h2000_0000);
    assign w_fifo_sel = (a[31:2] == 30'h2000_0001);
    assign w_stat_sel = (a[31:2] == 30'h2000_0002);

    // FIFO handshake: a push to a full FIFO is only accepted alongside a pop
    assign w_empty    = (r_count == 4'd0);
    assign w_full     = (r_count == c_DEPTH);
    assign out_valid  = !w_empty;
    assign out_data   = r_fifo[r_head];
    assign w_pop      = out_valid && out_ready;
    assign w_push_req = we && w_fifo_sel;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = we && w_stat_sel && wd[6];

    assign w_status = {25'd0, r_ovf, r_count, w_full, w_empty};

    // Read mux: combinational from the address and current state
    always_comb begin
        rd = 32'd0;
        if (w_ram_sel) begin
            rd = r_ram[w_idx];
        end else if (w_cnt_sel) begin
            rd = r_counter;
        end else if (w_stat_sel) begin
            rd = w_status;
        end
    end

    // RAM storage: written on a clock edge, never cleared by reset
    always_ff @(posedge clk) begin
        if (we && w_ram_sel) begin
            r_ram[w_idx] <= wd;
        end
    end

    // FIFO storage: a push while full-with-pop overwrites the slot being popped
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_tail] <= wd;
        end
    end

    // Free-running counter; a bus write takes priority over the increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= 32'd0;
        end else if (we && w_cnt_sel) begin
            r_counter <= wd;
        end else begin
            r_counter <= r_counter + 32'd1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 4'd0;
        end else begin
            if (w_push_ok) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 4'd1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    // Sticky overflow flag; an explicit clear wins over a simultaneous set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbus_responder
// Description : Directed bench for dbus_responder; FIFO output words are
//               checked by a monitor against a queue of expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_responder;

    localparam logic [31:0] c_COUNTER = 32'h8000_0000;
    localparam logic [31:0] c_FDATA   = 32'h8000_0004;
    localparam logic [31:0] c_STATUS  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    dbus_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .a         (a),
        .wd        (wd),
        .rd        (rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        wd = data;
        we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        a  = addr;
        we = 1'b0;
        #1;
        check(name, rd, exp);
    endtask

    // Monitor: every accepted output word must match the next expected one
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected actual=%08h required=none", out_data);
            end else begin
                check("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        read_check("rst_status", c_STATUS, 32'h0000_0001);
        read_check("rst_counter", c_COUNTER, 32'd0);
        tick();
        reset = 1'b0;

        // Counter runs from 0 after reset, then a loaded value wraps
        repeat (5) tick();
        read_check("cnt_after5", c_COUNTER, 32'd5);
        bus_write(c_COUNTER, 32'hFFFF_FFFE);
        read_check("cnt_loaded", c_COUNTER, 32'hFFFF_FFFE);
        tick();
        read_check("cnt_max", c_COUNTER, 32'hFFFF_FFFF);
        tick();
        read_check("cnt_wrap", c_COUNTER, 32'd0);

        // RAM write/read, ignored byte bits, unmapped reads
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        read_check("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        read_check("ram_rd_lowbits", 32'h0000_0012, 32'hDEAD_BEEF);
        read_check("unmapped_110", 32'h0000_0110, 32'd0);
        read_check("fdata_reads0", c_FDATA, 32'd0);
        tick();

        // Unmapped writes must not alias into RAM
        bus_write(32'h0000_0000, 32'h0000_00A5);
        bus_write(32'h0000_0100, 32'h0000_005A);
        bus_write(32'h8000_000C, 32'h1234_5678);
        read_check("ram0_no_alias", 32'h0000_0000, 32'h0000_00A5);
        read_check("unmapped_c", 32'h8000_000C, 32'd0);

        // No same-cycle write-through
        bus_write(32'h0000_0014, 32'h1111_1111);
        a  = 32'h0000_0014;
        wd = 32'h2222_2222;
        we = 1'b1;
        #1;
        check("no_writethrough", rd, 32'h1111_1111);
        tick();
        we = 1'b0;
        read_check("ram_second_write", 32'h0000_0014, 32'h2222_2222);

        // Fill with sink stalled; fifth push overflows
        out_ready = 1'b0;
        exp_q.push_back(32'd1);
        bus_write(c_FDATA, 32'd1);
        read_check("status_one", c_STATUS, 32'h0000_0004);
        for (int i = 2; i <= 4; i++) begin
            exp_q.push_back(32'(i));
            bus_write(c_FDATA, 32'(i));
        end
        read_check("status_full", c_STATUS, 32'h0000_0012);
        bus_write(c_FDATA, 32'd5);
        read_check("status_ovf", c_STATUS, 32'h0000_0052);
        check("head_is_1", out_data, 32'd1);
        tick();
        check("head_stable", out_data, 32'd1);

        // Push into a full FIFO together with a pop
        out_ready = 1'b1;
        exp_q.push_back(32'd9);
        bus_write(c_FDATA, 32'd9);
        out_ready = 1'b0;
        read_check("status_full_pp", c_STATUS, 32'h0000_0052);
        check("head_is_2", out_data, 32'd2);

        // Overflow clear only by bit 6
        bus_write(c_STATUS, 32'hFFFF_FFBF);
        read_check("ovf_kept", c_STATUS, 32'h0000_0052);
        bus_write(c_STATUS, 32'h0000_0040);
        read_check("ovf_cleared", c_STATUS, 32'h0000_0012);
        check("head_after_clr", out_data, 32'd2);

        // Drain: 2, 3, 4, 9
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        read_check("status_drained", c_STATUS, 32'h0000_0001);
        check("q_drained", 32'(exp_q.size()), 32'd0);

        // Refill across the pointer wrap, pop one, then reset mid-drain
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'(i * 256));
            bus_write(c_FDATA, 32'(i * 256));
        end
        out_ready = 1'b1;
        tick();
        read_check("status_three", c_STATUS, 32'h0000_000C);
        #1;
        reset     = 1'b1;
        out_ready = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        read_check("midrst_status", c_STATUS, 32'h0000_0001);
        read_check("midrst_counter", c_COUNTER, 32'd0);
        exp_q.delete();
        tick();
        tick();
        read_check("rst_hold_status", c_STATUS, 32'h0000_0001);
        reset = 1'b0;
        read_check("post_rst_cnt0", c_COUNTER, 32'd0);
        tick();
        read_check("post_rst_cnt1", c_COUNTER, 32'd1);
        read_check("ram_survives_rst", 32'h0000_0010, 32'hDEAD_BEEF);

        // Push to an empty FIFO with the sink ready: push only, pop next cycle
        out_ready = 1'b1;
        exp_q.push_back(32'h0000_0077);
        bus_write(c_FDATA, 32'h0000_0077);
        check("empty_push_valid", {31'd0, out_valid}, 32'd1);
        check("empty_push_data", out_data, 32'h0000_0077);
        tick();
        out_ready = 1'b0;
        read_check("status_final", c_STATUS, 32'h0000_0001);
        check("q_final", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, meaning the number of 32-bit RAM words; power of two, maximum 64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the output FIFO entries; power of two, 2..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port we, input, 1 bit: core data-bus write strobe.
REQ-006 SHALL have port a, input, 32 bits: core data-bus byte address; a[1:0] ignored.
REQ-007 SHALL have port wd, input, 32 bits: core write data.
REQ-008 SHALL have port rd, output, 32 bits: read data, combinational from a and current state.
REQ-009 SHALL have port out_data, output, 32 bits: FIFO head word.
REQ-010 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-011 SHALL have port out_ready, input, 1 bit: external sink accepts the head word.

Function
REQ-012 SHALL decode the RAM region when a[31:8]==0, at word index a[2+log2(RAM_WORDS)-1:2]; upper index bits alias.
REQ-013 SHALL decode COUNTER at 0x8000_0000, FIFO_DATA at 0x8000_0004 and STATUS at 0x8000_0008; every other address is unmapped.
REQ-014 SHALL return rd=0 for unmapped addresses and ignore writes to them.
REQ-015 SHALL read RAM combinationally and write RAM at posedge when we=1.
REQ-016 SHALL increment COUNTER by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-017 SHALL load wd into COUNTER on a write to COUNTER, taking priority over the increment in that cycle.
REQ-018 SHALL push wd into the FIFO on a write to FIFO_DATA when the FIFO is not full; FIFO_DATA reads return 0.
REQ-019 SHALL pop the head entry at posedge when out_valid=1 and out_ready=1.
REQ-020 SHALL accept a push to a full FIFO that coincides with a pop; count is unchanged, order is preserved, and no overflow is flagged.
REQ-021 SHALL drop a push to a full FIFO without a pop, leave the FIFO contents unchanged, and set the sticky overflow bit.
REQ-022 SHALL perform only the push on a push to an empty FIFO; no pop occurs in that cycle because out_valid=0.
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drive STATUS as: bit0 empty, bit1 full, bits[5:2] count (0..FIFO_DEPTH), bit6 overflow, bits[31:7] zero.
REQ-025 SHALL clear overflow on a STATUS write with wd[6]=1; other STATUS write bits are ignored.
REQ-026 SHALL give an overflow clear priority over an overflow set occurring in the same cycle.
REQ-027 SHALL make every write visible to rd on the following cycle; there is no same-cycle write-through.
REQ-028 SHALL use circular head/tail pointers that wrap modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, while reset=1 and independent of clk, set COUNTER=0, empty the FIFO (count=0, pointers 0), clear overflow and drive out_valid=0.
REQ-030 SHALL NOT reset RAM contents.
REQ-031 SHALL, when reset is asserted mid-operation, discard all queued FIFO data and any in-flight push or pop.
REQ-032 SHALL resume COUNTER incrementing from 0 on the first posedge after reset deasserts.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to 0x0000_0010, then read 0x10 next cycle -> rd=0xDEADBEEF; read 0x0000_0110 -> rd=0.
REQ-034 SHALL cover: release reset, wait 5 cycles, read COUNTER -> 5; write 0xFFFF_FFFE, then 2 cycles later -> 0x0000_0000.
REQ-035 SHALL cover: with out_ready=0, push 1,2,3,4,5 -> STATUS=0x52 (full, count 4, overflow); out_data=1; word 5 lost.
REQ-036 SHALL cover: with the FIFO full, push 9 while out_ready=1 -> pop 1, push 9 accepted, count stays 4; draining yields 2,3,4,9.
REQ-037 SHALL cover: write STATUS with wd=0x40 -> overflow cleared, STATUS bit6=0; FIFO contents unaffected.
REQ-038 SHALL cover: assert reset asynchronously mid-drain with 3 entries queued -> out_valid=0 immediately, STATUS=0x01, COUNTER=0.
